// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the run-time clock-divider controller.
package clkdiv_pkg;

    localparam int unsigned CntWDefault    = 32;
    localparam int unsigned DefHalfDefault = 2;  // 100 MHz in, 25 MHz out

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StLoad
    } state_e;

    function automatic logic state_busy(state_e s);
        return (s == StDrain) || (s == StLoad);
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Configuration handshake and divided-clock outputs of the divider controller.
interface clkdiv_if #(
    parameter int unsigned CNT_W = clkdiv_pkg::CntWDefault
) ();

    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             clkout;
    logic             tick;
    logic             busy;
    logic             cfg_err;

    modport master (
        output run, cfg_valid, cfg_half,
        input  cfg_ready, clkout, tick, busy, cfg_err
    );

    modport slave (
        input  run, cfg_valid, cfg_half,
        output cfg_ready, clkout, tick, busy, cfg_err
    );

endinterface

// File: rtl/clkdiv_core.sv
// Half-period counter with registered divided clock and rising-edge tick.
module clkdiv_core #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             park_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_o,
    output logic             clkout_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;
    logic [CNT_W:0]   count_inc;
    logic             hit;

    // One extra bit so count + 1 cannot wrap before the compare.
    assign count_inc = {1'b0, count_q} + (CNT_W + 1)'(1);
    assign hit       = count_inc >= {1'b0, limit_i};

    always_comb begin
        count_d  = count_q;
        clkout_d = clkout_q;
        tick_d   = 1'b0;
        if (clr_i) begin
            count_d  = '0;
            clkout_d = 1'b0;
        end else if (en_i) begin
            if (hit) begin
                count_d = '0;
                if (clkout_q) begin
                    clkout_d = 1'b0;
                end else if (!park_i) begin
                    clkout_d = 1'b1;
                    tick_d   = 1'b1;
                end
            end else begin
                count_d = count_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
        end
    end

    assign hit_o    = hit;
    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Sequences start, stop and reload of the divider so clkout never shows a runt phase.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W    = CntWDefault,
    parameter int unsigned DEF_HALF = DefHalfDefault
) (
    input  logic     clkin,
    input  logic     rst_n,
    clkdiv_if.slave  bus_io
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_err_q, cfg_err_d;

    logic cfg_ready;
    logic cfg_fire;
    logic cfg_ok;
    logic core_en;
    logic core_park;
    logic core_clr;
    logic core_hit;

    assign cfg_ready = (state_q == StIdle) || (state_q == StRun);
    assign cfg_fire  = bus_io.cfg_valid && cfg_ready;
    assign cfg_ok    = cfg_fire && (bus_io.cfg_half != '0);

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        core_en    = 1'b0;
        core_park  = 1'b0;
        core_clr   = 1'b0;
        cfg_err_d  = cfg_fire && (bus_io.cfg_half == '0);

        unique case (state_q)
            StIdle: begin
                core_clr = 1'b1;
                if (cfg_ok) begin
                    pend_d     = bus_io.cfg_half;
                    pend_vld_d = 1'b1;
                    state_d    = StLoad;
                end else if (bus_io.run) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                core_en = 1'b1;
                if (cfg_ok) begin
                    pend_d     = bus_io.cfg_half;
                    pend_vld_d = 1'b1;
                    state_d    = StDrain;
                end else if (!bus_io.run) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Keep counting but never start a new high phase.
                core_en   = 1'b1;
                core_park = 1'b1;
                if (core_hit) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                core_clr = 1'b1;
                if (pend_vld_q) begin
                    limit_d    = pend_q;
                    pend_vld_d = 1'b0;
                end
                state_d = bus_io.run ? StRun : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            limit_q    <= CNT_W'(DEF_HALF);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    clkdiv_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .en_i     (core_en),
        .park_i   (core_park),
        .clr_i    (core_clr),
        .limit_i  (limit_q),
        .hit_o    (core_hit),
        .clkout_o (bus_io.clkout),
        .tick_o   (bus_io.tick)
    );

    assign bus_io.cfg_ready = cfg_ready;
    assign bus_io.busy      = state_busy(state_q);
    assign bus_io.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: start, illegal cfg, reload, stop, back-to-back, reset in drain.
module tb_clkdiv_ctrl;

    localparam int unsigned CntW = 32;

    logic clkin = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    clkdiv_if #(.CNT_W(CntW)) bus ();

    clkdiv_ctrl #(
        .CNT_W    (CntW),
        .DEF_HALF (2)
    ) dut (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clkin = ~clkin;

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.run       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_half  = '0;
        #12;
        n_chk++;
        if (bus.clkout !== 1'b0) begin
            n_fail++; $display("FAIL reset.clkout got %b want 0", bus.clkout);
        end
        n_chk++;
        if (bus.tick !== 1'b0) begin
            n_fail++; $display("FAIL reset.tick got %b want 0", bus.tick);
        end
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset.busy got %b want 0", bus.busy);
        end
        n_chk++;
        if (bus.cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset.cfg_err got %b want 0", bus.cfg_err);
        end
        n_chk++;
        if (bus.cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset.cfg_ready got %b want 1", bus.cfg_ready);
        end
        @(negedge clkin);
        rst_n = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step();
            n_chk++;
            if (bus.clkout !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle.hold j=%0d got clkout=%b busy=%b want 0 0",
                         j, bus.clkout, bus.busy);
            end
        end
    endtask

    task automatic test_default_start();
        logic exp_clk, exp_tick;
        for (int j = 1; j <= 12; j++) begin
            if (j == 1) bus.run = 1'b1;
            step();
            exp_clk  = (j >= 3) && (((j - 3) % 4) < 2);
            exp_tick = (j >= 3) && (((j - 3) % 4) == 0);
            n_chk++;
            if (bus.clkout !== exp_clk) begin
                n_fail++;
                $display("FAIL start.clkout j=%0d got %b want %b", j, bus.clkout, exp_clk);
            end
            n_chk++;
            if (bus.tick !== exp_tick) begin
                n_fail++;
                $display("FAIL start.tick j=%0d got %b want %b", j, bus.tick, exp_tick);
            end
            n_chk++;
            if (bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL start.busy j=%0d got %b want 0", j, bus.busy);
            end
        end
    endtask

    task automatic test_illegal_cfg();
        logic exp_clk, exp_tick, exp_err;
        for (int j = 1; j <= 8; j++) begin
            if (j == 1) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_half  = '0;
            end
            if (j == 2) bus.cfg_valid = 1'b0;
            step();
            exp_err  = (j == 1);
            exp_clk  = (((j - 1) % 4) >= 2);
            exp_tick = (j == 3) || (j == 7);
            n_chk++;
            if (bus.cfg_err !== exp_err) begin
                n_fail++;
                $display("FAIL illegal.cfg_err j=%0d got %b want %b", j, bus.cfg_err, exp_err);
            end
            n_chk++;
            if (bus.clkout !== exp_clk) begin
                n_fail++;
                $display("FAIL illegal.clkout j=%0d got %b want %b", j, bus.clkout, exp_clk);
            end
            n_chk++;
            if (bus.tick !== exp_tick) begin
                n_fail++;
                $display("FAIL illegal.tick j=%0d got %b want %b", j, bus.tick, exp_tick);
            end
            n_chk++;
            if (bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL illegal.busy j=%0d got %b want 0", j, bus.busy);
            end
        end
    endtask

    task automatic test_reload();
        logic exp_clk, exp_tick, exp_busy;
        for (int j = 1; j <= 20; j++) begin
            if (j == 1) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_half  = 32'd5;
            end
            if (j == 2) bus.cfg_valid = 1'b0;
            step();
            exp_busy = (j <= 3);
            exp_clk  = ((j >= 9) && (j <= 13)) || (j >= 19);
            exp_tick = (j == 9) || (j == 19);
            n_chk++;
            if (bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL reload.busy j=%0d got %b want %b", j, bus.busy, exp_busy);
            end
            n_chk++;
            if (bus.cfg_ready !== !exp_busy) begin
                n_fail++;
                $display("FAIL reload.cfg_ready j=%0d got %b want %b", j, bus.cfg_ready,
                         !exp_busy);
            end
            n_chk++;
            if (bus.clkout !== exp_clk) begin
                n_fail++;
                $display("FAIL reload.clkout j=%0d got %b want %b", j, bus.clkout, exp_clk);
            end
            n_chk++;
            if (bus.tick !== exp_tick) begin
                n_fail++;
                $display("FAIL reload.tick j=%0d got %b want %b", j, bus.tick, exp_tick);
            end
        end
    endtask

    task automatic test_stop();
        logic exp_clk, exp_busy;
        for (int j = 1; j <= 12; j++) begin
            if (j == 1) bus.run = 1'b0;
            step();
            exp_clk  = (j <= 3);
            exp_busy = (j <= 4);
            n_chk++;
            if (bus.clkout !== exp_clk) begin
                n_fail++;
                $display("FAIL stop.clkout j=%0d got %b want %b", j, bus.clkout, exp_clk);
            end
            n_chk++;
            if (bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL stop.busy j=%0d got %b want %b", j, bus.busy, exp_busy);
            end
            n_chk++;
            if (bus.tick !== 1'b0) begin
                n_fail++; $display("FAIL stop.tick j=%0d got %b want 0", j, bus.tick);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_clk, exp_tick, exp_busy;
        for (int j = 1; j <= 28; j++) begin
            if (j == 1) begin
                bus.run       = 1'b1;
                bus.cfg_valid = 1'b1;
                bus.cfg_half  = 32'd3;
            end
            if (j == 2) bus.cfg_half = 32'd7;
            if (j == 4) bus.cfg_valid = 1'b0;
            step();
            exp_busy = (j == 1) || ((j >= 3) && (j <= 5));
            exp_clk  = ((j >= 13) && (j <= 19)) || (j >= 27);
            exp_tick = (j == 13) || (j == 27);
            n_chk++;
            if (bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b.busy j=%0d got %b want %b", j, bus.busy, exp_busy);
            end
            n_chk++;
            if (bus.cfg_ready !== !exp_busy) begin
                n_fail++;
                $display("FAIL b2b.cfg_ready j=%0d got %b want %b", j, bus.cfg_ready, !exp_busy);
            end
            n_chk++;
            if (bus.clkout !== exp_clk) begin
                n_fail++;
                $display("FAIL b2b.clkout j=%0d got %b want %b", j, bus.clkout, exp_clk);
            end
            n_chk++;
            if (bus.tick !== exp_tick) begin
                n_fail++;
                $display("FAIL b2b.tick j=%0d got %b want %b", j, bus.tick, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic exp_clk, exp_tick;
        bus.cfg_valid = 1'b1;
        bus.cfg_half  = 32'd9;
        step();
        bus.cfg_valid = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b1 || bus.clkout !== 1'b1) begin
            n_fail++;
            $display("FAIL rstdrain.enter got busy=%b clkout=%b want 1 1", bus.busy, bus.clkout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.clkout !== 1'b0) begin
            n_fail++; $display("FAIL rstdrain.clkout got %b want 0", bus.clkout);
        end
        n_chk++;
        if (bus.tick !== 1'b0) begin
            n_fail++; $display("FAIL rstdrain.tick got %b want 0", bus.tick);
        end
        n_chk++;
        if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstdrain.state got busy=%b ready=%b want 0 1", bus.busy, bus.cfg_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            exp_clk  = (j >= 3) && (((j - 3) % 4) < 2);
            exp_tick = (j >= 3) && (((j - 3) % 4) == 0);
            n_chk++;
            if (bus.clkout !== exp_clk) begin
                n_fail++;
                $display("FAIL rstdrain.clkout j=%0d got %b want %b", j, bus.clkout, exp_clk);
            end
            n_chk++;
            if (bus.tick !== exp_tick) begin
                n_fail++;
                $display("FAIL rstdrain.tick j=%0d got %b want %b", j, bus.tick, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_start();
        test_illegal_cfg();
        test_reload();
        test_stop();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
